// File: rtl/seq_detect_1011.sv
// Moore-style serial detector for the bit sequence 1011 (MSB first) on en-qualified bits.
// Define SEQ_DETECT_OVERLAP_EN to let a detected pattern's trailing bits seed the next match.
module seq_detect_1011 #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             d,
  input  logic             clr,
  output logic             match,
  output logic [CNT_W-1:0] match_cnt,
  output logic [2:0]       state_o
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_1    = 3'd1,
    S_10   = 3'd2,
    S_101  = 3'd3,
    S_HIT  = 3'd4
  } state_t;

  // Kept as a raw 3-bit vector so the illegal codes 5-7 remain representable and recoverable.
  logic [2:0] state;
  state_t     next_state;
  logic       hit;

  always_comb begin
    // NOTE: defaults first so every path assigns next_state and hit; otherwise latches are inferred.
    next_state = state_t'(state);
    hit        = 1'b0;
    case (state)
      S_IDLE:  if (en) next_state = d ? S_1   : S_IDLE;
      S_1:     if (en) next_state = d ? S_1   : S_10;
      S_10:    if (en) next_state = d ? S_101 : S_IDLE;
      S_101:   if (en) next_state = d ? S_HIT : S_10;
`ifdef SEQ_DETECT_OVERLAP_EN
      S_HIT:   if (en) next_state = d ? S_1   : S_10;
`else
      S_HIT:   if (en) next_state = d ? S_1   : S_IDLE;
`endif
      default: next_state = S_IDLE;
    endcase
    hit = en && (next_state == S_HIT);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      match     <= 1'b0;
      match_cnt <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state <= next_state;
      match <= hit;
      // clr outranks a coincident detection; the counter saturates instead of wrapping.
      if (clr)
        match_cnt <= '0;
      else if (hit && (match_cnt != {CNT_W{1'b1}}))
        match_cnt <= match_cnt + CNT_W'(1);
    end
  end

  assign state_o = state;

endmodule

// File: tb/tb_seq_detect_1011.sv
// Directed self-checking bench for seq_detect_1011 (default CNT_W=8 plus a CNT_W=2 copy for saturation).
module tb_seq_detect_1011;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en  = 1'b0;
  logic       d   = 1'b0;
  logic       clr = 1'b0;

  logic       match;
  logic [7:0] match_cnt;
  logic [2:0] state_o;

  logic       match2;
  logic [1:0] match_cnt2;
  logic [2:0] state_o2;

  int vectors     = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  seq_detect_1011 #(.CNT_W(8)) dut (
    .clk(clk), .rst(rst), .en(en), .d(d), .clr(clr),
    .match(match), .match_cnt(match_cnt), .state_o(state_o)
  );

  seq_detect_1011 #(.CNT_W(2)) dut2 (
    .clk(clk), .rst(rst), .en(en), .d(d), .clr(clr),
    .match(match2), .match_cnt(match_cnt2), .state_o(state_o2)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Drive one bit between edges, then sample 1 time unit after the rising edge.
  task automatic step(input logic e, input logic b, input logic c = 1'b0);
    @(negedge clk);
    en  = e;
    d   = b;
    clr = c;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    en  = 1'b0;
    d   = 1'b0;
    clr = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  logic       ov_bits  [7] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
  logic       ov_match [7];
  logic [7:0] ov_cnt;
  logic [1:0] sat_cnt  [5] = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};

  initial begin
`ifdef SEQ_DETECT_OVERLAP_EN
    ov_match = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    ov_cnt   = 8'd2;
`else
    ov_match = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    ov_cnt   = 8'd1;
`endif

    // Reset state
    do_reset();
    check("rst_state", state_o, 3'd0);
    check("rst_match", match, 1'b0);
    check("rst_cnt", match_cnt, 8'd0);

    // Basic detection 1011
    step(1'b1, 1'b1);
    check("basic_b1_match", match, 1'b0);
    step(1'b1, 1'b0);
    step(1'b1, 1'b1);
    check("basic_b3_state", state_o, 3'd3);
    check("basic_b3_match", match, 1'b0);
    step(1'b1, 1'b1);
    check("basic_hit_match", match, 1'b1);
    check("basic_hit_cnt", match_cnt, 8'd1);
    check("basic_hit_state", state_o, 3'd4);
    step(1'b1, 1'b0);
    check("basic_after_match", match, 1'b0);

    // Mid-pattern asynchronous reset (state reaches S_101 in either build)
    step(1'b1, 1'b1);
    step(1'b1, 1'b0);
    step(1'b1, 1'b1);
    check("mid_pre_state", state_o, 3'd3);
    check("mid_pre_cnt", match_cnt, 8'd1);
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("mid_async_state", state_o, 3'd0);
    check("mid_async_cnt", match_cnt, 8'd0);
    @(negedge clk);
    rst = 1'b0;
    step(1'b1, 1'b1);
    check("mid_rel_match", match, 1'b0);
    check("mid_rel_state", state_o, 3'd1);
    step(1'b1, 1'b0);
    step(1'b1, 1'b1);
    check("mid_rel_b3_match", match, 1'b0);
    step(1'b1, 1'b1);
    check("mid_rel_hit_match", match, 1'b1);
    check("mid_rel_hit_cnt", match_cnt, 8'd1);

    // Enable gating
    do_reset();
    step(1'b1, 1'b1);
    step(1'b1, 1'b0);
    step(1'b0, 1'b1);
    check("en_hold1_state", state_o, 3'd2);
    check("en_hold1_match", match, 1'b0);
    step(1'b0, 1'b1);
    check("en_hold2_state", state_o, 3'd2);
    step(1'b0, 1'b0);
    check("en_hold3_state", state_o, 3'd2);
    step(1'b1, 1'b1);
    check("en_b3_match", match, 1'b0);
    step(1'b1, 1'b1);
    check("en_hit_match", match, 1'b1);
    check("en_hit_cnt", match_cnt, 8'd1);
    step(1'b0, 1'b1);
    check("en_hit_hold_match", match, 1'b0);
    check("en_hit_hold_state", state_o, 3'd4);

    // Overlap behaviour on 1011011
    do_reset();
    for (int i = 0; i < 7; i++) begin
      step(1'b1, ov_bits[i]);
      check($sformatf("ovl_bit%0d_match", i + 1), match, ov_match[i]);
    end
    check("ovl_cnt", match_cnt, ov_cnt);

    // Saturation and clear on the CNT_W=2 instance
    do_reset();
    for (int p = 0; p < 5; p++) begin
      step(1'b1, 1'b1);
      step(1'b1, 1'b0);
      step(1'b1, 1'b1);
      step(1'b1, 1'b1);
      check($sformatf("sat_p%0d_match", p + 1), match2, 1'b1);
      check($sformatf("sat_p%0d_cnt", p + 1), match_cnt2, sat_cnt[p]);
    end
    check("sat_wide_cnt", match_cnt, 8'd5);
    step(1'b1, 1'b1);
    step(1'b1, 1'b0);
    step(1'b1, 1'b1);
    step(1'b1, 1'b1, 1'b1);
    check("clr_hit_match", match2, 1'b1);
    check("clr_hit_cnt", match_cnt2, 2'd0);
    check("clr_hit_wide_cnt", match_cnt, 8'd0);
    step(1'b1, 1'b0);
    check("clr_after_match", match2, 1'b0);

    // Illegal state recovery with en=0
    do_reset();
    @(negedge clk);
    en = 1'b0;
    d  = 1'b1;
    force dut.state = 3'd6;
    #1;
    release dut.state;
    @(posedge clk);
    #1;
    check("ill_state", state_o, 3'd0);
    check("ill_match", match, 1'b0);
    step(1'b1, 1'b1);
    check("ill_resume_state", state_o, 3'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/seq_detect_1011.md
Name: seq_detect_1011

Overview:
- Moore-style serial pattern detector. Sits directly downstream of the enable-gated D flip-flop stage and consumes its registered serial bit (q) as input d.
- Detects the bit sequence 1011, MSB first, on bits sampled while en=1.
- Emits a one-cycle match pulse and keeps a saturating match counter for the state-machine test harness.

Parameters:
- CNT_W, 8, width of match counter; counter saturates at 2^CNT_W-1.

Ports:
- clk  input  1  system clock, all state on rising edge
- rst  input  1  asynchronous, active-high reset
- en  input  1  bit-valid qualifier; d sampled only when en=1
- d  input  1  serial data bit (q of upstream DFF stage)
- clr  input  1  synchronous clear of match_cnt only; FSM unaffected
- match  output  1  one-cycle pulse, registered
- match_cnt  output  CNT_W  saturating count of detections
- state_o  output  3  current FSM state encoding, debug

Behaviour:
- Reset: one clock and one reset. The reset is asynchronous and active-high. rst=1 forces state=S_IDLE, match=0 and match_cnt=0 immediately, without waiting for a clock edge. Release takes effect at the first rising edge after deassertion.
- State encodings: S_IDLE=3'd0, S_1=3'd1, S_10=3'd2, S_101=3'd3, S_HIT=3'd4. Encodings 5-7 are illegal and go to S_IDLE on the next edge regardless of en.
- Transitions, taken only when en=1 (d=1 / d=0):
  - S_IDLE: 1→S_1, 0→S_IDLE
  - S_1: 1→S_1, 0→S_10
  - S_10: 1→S_101, 0→S_IDLE
  - S_101: 1→S_HIT, 0→S_10
  - S_HIT: see Optional Feature
- en=0: state holds, d is ignored, match=0 on the next edge.
- match is registered: match <= en && (next_state==S_HIT).
  - It is high for exactly the one cycle after the edge that samples the 4th pattern bit, so latency is 1 cycle from the last bit's sampling edge.
  - Staying in S_HIT with en=0 does not re-pulse.
- match_cnt update on each edge, in priority order:
  - clr=1: cleared to 0. clr has priority over a simultaneous increment, so that detection is lost.
  - Otherwise, on a match condition: increments by 1, holding at all-ones, with no wrap to 0.
- state_o is a direct copy of the state register.
- rst asserted mid-pattern discards partial progress. After release, a full 4-bit 1011 is required before the next match.
- clr does not affect FSM progress; a pattern in flight completes normally.

Optional Feature:
- Macro: SEQ_DETECT_OVERLAP_EN
- Defined: overlapping detection. From S_HIT: d=1→S_1, d=0→S_10. The trailing "1" is reused as a prefix.
- Undefined (default): non-overlapping detection. From S_HIT: d=1→S_1, d=0→S_IDLE. No bit of a detected pattern contributes to the next one.
- All other transitions, the reset behaviour and the counter are identical in both builds.

Test Plan:
- Basic detection: reset 2 cycles, then en=1, d=1,0,1,1 on 4 consecutive edges → match=1 only in cycle 5, match_cnt=1, state_o=4. Then d=0 → match=0.
- Overlap: d stream 1,0,1,1,0,1,1 with en=1.
  - SEQ_DETECT_OVERLAP_EN defined → match pulses after bits 4 and 7, match_cnt=2.
  - Undefined → single pulse after bit 4, match_cnt=1.
- Enable gating: en=1 for d=1,0; en=0 for 3 cycles with d toggling 1,1,0; en=1 for d=1,1 → one match after the final bit, state_o holds 2 during the en=0 cycles, match_cnt=1.
- Reset mid-operation: feed 1,0,1, assert rst asynchronously between edges → state_o=0 and match_cnt=0 immediately. After release, feed d=1 → no match; then feed 0,1,1 → match.
- Saturation and clear with CNT_W=2: 5 back-to-back 1011 patterns → match_cnt =1,2,3,3,3. Then clr=1 on the same edge as a 6th detection → match_cnt=0, match still pulses.
- Illegal state recovery: force state to 3'd6 via the bench → state_o=0 after next edge with en=0, match stays 0.
